// File: rtl/control_pkg.sv
// Shared encodings for the multi-cycle control FSM: state values, one-hot
// instruction-type bit positions and the bundle of registered control strobes.
package control_pkg;

    typedef enum logic [2:0] {
        StFetch     = 3'd0,
        StDecode    = 3'd1,
        StExecute   = 3'd2,
        StMemory    = 3'd3,
        StWriteback = 3'd4,
        StTrap      = 3'd5
    } state_e;

    localparam int unsigned CodeJ    = 0;
    localparam int unsigned CodeJalr = 1;
    localparam int unsigned CodeLui  = 2;
    localparam int unsigned CodeAuipc = 3;
    localparam int unsigned CodeB    = 4;
    localparam int unsigned CodeR    = 5;
    localparam int unsigned CodeS    = 6;
    localparam int unsigned CodeIAlu = 7;
    localparam int unsigned CodeLoad = 8;
    localparam int unsigned CodeCsr  = 9;
    localparam int unsigned NumCodes = 10;

    typedef struct packed {
        logic mem_read;
        logic mem_write;
        logic pc_load;
        logic rd_write;
        logic alu_sel_a;
        logic alu_sel_b;
        logic trap;
    } ctrl_t;

    // Strobes seen in FETCH, which is also the value held while in reset.
    localparam ctrl_t CtrlReset = '{mem_read: 1'b1, default: 1'b0};

endpackage

// File: rtl/wait_counter.sv
// Counts consecutive cycles spent waiting on the memory handshake and flags
// when the allowed number of wait cycles has been used up.
module wait_counter #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic expired
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    logic [CntW-1:0] count_q;
    logic [CntW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = count_q + CntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == CntW'(TIMEOUT));

endmodule

// File: rtl/control_fsm.sv
// Multi-cycle instruction control FSM: fetch/decode/execute/memory/writeback
// sequencing with a memory-wait timeout and an absorbing trap state.
module control_fsm
    import control_pkg::*;
#(
    parameter int unsigned CODE_W  = 10,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] code,
    input  logic              mem_ready,
    output logic              mem_read,
    output logic              mem_write,
    output logic              ir_load,
    output logic              pc_load,
    output logic              rd_write,
    output logic              alu_sel_a,
    output logic              alu_sel_b,
    output logic              trap,
    output logic [2:0]        state_o
);

    state_e            state_q;
    state_e            state_d;
    logic [CODE_W-1:0] code_q;
    logic [CODE_W-1:0] code_d;
    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;

    logic code_legal;
    logic expired;
    logic cnt_clr;
    logic cnt_inc;
    logic waiting;

    // Moore strobes for a given state and latched instruction type.
    function automatic ctrl_t moore_ctrl(input state_e st, input logic [CODE_W-1:0] c);
        ctrl_t o;
        o = '0;
        case (st)
            StFetch: begin
                o.mem_read = 1'b1;
            end
            StExecute: begin
                o.alu_sel_a = c[CodeJ] | c[CodeAuipc];
                o.alu_sel_b = ~(c[CodeR] | c[CodeB]);
            end
            StMemory: begin
                o.mem_read  = c[CodeLoad];
                o.mem_write = c[CodeS];
            end
            StWriteback: begin
                o.pc_load  = 1'b1;
                o.rd_write = ~(c[CodeB] | c[CodeS]);
            end
            StTrap: begin
                o.trap = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

    // Exactly one bit set, and CSR is not supported.
    assign code_legal = (code != '0) && ((code & (code - CODE_W'(1))) == '0) && !code[CodeCsr];

    assign waiting = (state_q == StFetch) || (state_q == StMemory);

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        unique case (state_q)
            StFetch: begin
                if (mem_ready) begin
                    state_d = StDecode;
                end else if (expired) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                code_d  = code;
                state_d = code_legal ? StExecute : StTrap;
            end
            StExecute: begin
                state_d = (code_q[CodeS] | code_q[CodeLoad]) ? StMemory : StWriteback;
            end
            StMemory: begin
                if (mem_ready) begin
                    state_d = StWriteback;
                end else if (expired) begin
                    state_d = StTrap;
                end
            end
            StWriteback: begin
                state_d = StFetch;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StTrap;
            end
        endcase
    end

    assign ctrl_d  = moore_ctrl(state_d, code_d);
    assign cnt_clr = (state_d != state_q) && ((state_d == StFetch) || (state_d == StMemory));
    assign cnt_inc = waiting && !mem_ready && !expired;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
            code_q  <= '0;
            ctrl_q  <= CtrlReset;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            ctrl_q  <= ctrl_d;
        end
    end

    wait_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .inc     (cnt_inc),
        .expired (expired)
    );

    assign mem_read  = ctrl_q.mem_read;
    assign mem_write = ctrl_q.mem_write;
    assign pc_load   = ctrl_q.pc_load;
    assign rd_write  = ctrl_q.rd_write;
    assign alu_sel_a = ctrl_q.alu_sel_a;
    assign alu_sel_b = ctrl_q.alu_sel_b;
    assign trap      = ctrl_q.trap;
    assign ir_load   = (state_q == StFetch) && mem_ready;
    assign state_o   = state_q;

    // Bits of the latched type code that drive no strobe (LUI, JALR, I-ALU, CSR, extras).
    logic unused_code_q;
    assign unused_code_q = ^code_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected cycle traces built from the
// instruction-level rules, replayed against the DUT and checked every cycle.
module tb_control_fsm;

    localparam int unsigned TIMEOUT = 15;
    localparam int unsigned CODE_W  = 10;

    localparam logic [2:0] SF = 3'd0;
    localparam logic [2:0] SD = 3'd1;
    localparam logic [2:0] SE = 3'd2;
    localparam logic [2:0] SM = 3'd3;
    localparam logic [2:0] SW = 3'd4;
    localparam logic [2:0] ST = 3'd5;

    typedef struct packed {
        logic [2:0] st;
        logic       mr;
        logic       mw;
        logic       ir;
        logic       pc;
        logic       rd;
        logic       sa;
        logic       sb;
        logic       tr;
    } outs_t;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              ready;
        outs_t             exp;
    } cyc_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [CODE_W-1:0] code;
    logic              mem_ready;
    logic              mem_read;
    logic              mem_write;
    logic              ir_load;
    logic              pc_load;
    logic              rd_write;
    logic              alu_sel_a;
    logic              alu_sel_b;
    logic              trap;
    logic [2:0]        state_o;

    int    vectors = 0;
    int    miscompares = 0;
    cyc_t  plan_q[$];
    outs_t exp_cur;
    logic  exp_valid = 1'b0;

    always #5 clk = ~clk;

    control_fsm #(
        .CODE_W  (CODE_W),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .code      (code),
        .mem_ready (mem_ready),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .ir_load   (ir_load),
        .pc_load   (pc_load),
        .rd_write  (rd_write),
        .alu_sel_a (alu_sel_a),
        .alu_sel_b (alu_sel_b),
        .trap      (trap),
        .state_o   (state_o)
    );

    function automatic outs_t mk(input logic [2:0] st, input logic mr, input logic mw,
                                 input logic ir, input logic pc, input logic rd,
                                 input logic sa, input logic sb, input logic tr);
        outs_t o;
        o.st = st; o.mr = mr; o.mw = mw; o.ir = ir; o.pc = pc;
        o.rd = rd; o.sa = sa; o.sb = sb; o.tr = tr;
        return o;
    endfunction

    function automatic outs_t act();
        return {state_o, mem_read, mem_write, ir_load, pc_load, rd_write,
                alu_sel_a, alu_sel_b, trap};
    endfunction

    function automatic logic [CODE_W-1:0] rnd_code();
        return CODE_W'($urandom);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom);
    endfunction

    task automatic check(input string name, input outs_t got, input outs_t want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %b want %b (st,mr,mw,ir,pc,rd,sa,sb,tr)", name, got, want);
        end
    endtask

    task automatic check_int(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic push(input logic [CODE_W-1:0] c, input logic r, input outs_t o);
        cyc_t e;
        e.code = c; e.ready = r; e.exp = o;
        plan_q.push_back(e);
    endtask

    task automatic plan_trap();
        for (int i = 0; i < 20; i++) push(rnd_code(), rnd_bit(), mk(ST, 0, 0, 0, 0, 0, 0, 0, 1));
    endtask

    // Expected trace of one instruction: fwait/mwait are stalled handshake cycles.
    task automatic plan_instr(input logic [CODE_W-1:0] c, input int fwait, input int mwait);
        logic legal;
        logic is_mem;
        legal  = ($countones(c) == 1) && !c[9];
        is_mem = c[6] | c[8];
        for (int i = 0; i < fwait && i <= int'(TIMEOUT); i++)
            push(rnd_code(), 1'b0, mk(SF, 1, 0, 0, 0, 0, 0, 0, 0));
        if (fwait > int'(TIMEOUT)) begin
            plan_trap();
            return;
        end
        push(rnd_code(), 1'b1, mk(SF, 1, 0, 1, 0, 0, 0, 0, 0));
        push(c, rnd_bit(), mk(SD, 0, 0, 0, 0, 0, 0, 0, 0));
        if (!legal) begin
            plan_trap();
            return;
        end
        push(rnd_code(), rnd_bit(), mk(SE, 0, 0, 0, 0, 0, c[0] | c[3], !(c[5] | c[4]), 0));
        if (is_mem) begin
            for (int i = 0; i < mwait && i <= int'(TIMEOUT); i++)
                push(rnd_code(), 1'b0, mk(SM, c[8], c[6], 0, 0, 0, 0, 0, 0));
            if (mwait > int'(TIMEOUT)) begin
                plan_trap();
                return;
            end
            push(rnd_code(), 1'b1, mk(SM, c[8], c[6], 0, 0, 0, 0, 0, 0));
        end
        push(rnd_code(), rnd_bit(), mk(SW, 0, 0, 0, 1, !(c[4] | c[6]), 0, 0, 0));
    endtask

    // Replays up to n planned cycles (n < 0: all); inputs change 1 time unit after posedge.
    task automatic play(input int n);
        int   k;
        cyc_t e;
        k = 0;
        while (plan_q.size() > 0 && (n < 0 || k < n)) begin
            e = plan_q.pop_front();
            code      = e.code;
            mem_ready = e.ready;
            exp_cur   = e.exp;
            exp_valid = 1'b1;
            @(posedge clk);
            #1;
            k++;
        end
        exp_valid = 1'b0;
    endtask

    task automatic do_reset();
        exp_valid = 1'b0;
        mem_ready = 1'b0;
        rst_n     = 1'b0;
        #2;
        check("reset_outs", act(), mk(SF, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        if (exp_valid && rst_n) check($sformatf("cycle_t%0t", $time), act(), exp_cur);
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        logic [CODE_W-1:0] others [5];
        others = '{10'h001, 10'h002, 10'h004, 10'h010, 10'h080};
        rst_n     = 1'b0;
        code      = '0;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        plan_instr(10'h020, 0, 0);
        check_int("rtype_cycles", plan_q.size(), 4);
        check_int("rtype_exec_sel", int'({plan_q[2].exp.sa, plan_q[2].exp.sb}), 0);
        play(-1);

        plan_instr(10'h008, 0, 0);
        check_int("auipc_exec_sel", int'({plan_q[2].exp.sa, plan_q[2].exp.sb}), 3);
        play(-1);

        plan_instr(10'h100, 1, 3);
        n = 0;
        foreach (plan_q[i]) if (plan_q[i].exp.st == SM && plan_q[i].exp.mr) n++;
        check_int("load_mem_read_cycles", n, 4);
        play(-1);

        plan_instr(10'h040, 0, 2);
        check_int("store_wb_rd_write", int'(plan_q[plan_q.size() - 1].exp.rd), 0);
        play(-1);

        foreach (others[i]) begin
            plan_instr(others[i], i, 0);
            play(-1);
        end

        plan_instr(10'h003, 0, 0);
        check_int("illegal_cycles", plan_q.size(), 22);
        play(-1);
        do_reset();
        plan_instr(10'h200, 2, 0);
        play(-1);
        do_reset();
        plan_instr(10'h000, 0, 0);
        play(-1);
        do_reset();

        plan_instr(10'h020, 16, 0);
        check_int("fetch_timeout_cycles", plan_q.size(), 36);
        play(-1);
        do_reset();
        plan_instr(10'h020, 15, 0);
        check_int("fetch_last_chance_cycles", plan_q.size(), 19);
        play(-1);

        plan_instr(10'h100, 0, 16);
        play(-1);
        do_reset();
        plan_instr(10'h100, 0, 15);
        play(-1);

        plan_instr(10'h040, 0, 10);
        play(5);
        plan_q.delete();
        check("mid_memory_store", act(), mk(SM, 0, 1, 0, 0, 0, 0, 0, 0));
        mem_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_mid_memory", act(), mk(SF, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        plan_instr(10'h020, 1, 0);
        play(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
